// File: rtl/axi_lite_pkg.sv
// Shared response codes and write-channel state encoding for the AXI4-Lite register file.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi_lite_write_ctrl.sv
// AW/W capture, write FSM and B channel; hands one commit per write to the register array.
module axi_lite_write_ctrl
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int NUM_REGS      = 8,
  parameter int IDX_W         = ADDRESS_WIDTH - $clog2(DATA_WIDTH / 8)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr_i,
  input  logic                      awvalid_i,
  output logic                      awready_o,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,
  output logic [1:0]                bresp_o,
  output logic                      bvalid_o,
  input  logic                      bready_i,
  output logic                      commit_o,
  output logic [IDX_W-1:0]          commit_idx_o,
  output logic [DATA_WIDTH-1:0]     commit_data_o,
  output logic [DATA_WIDTH/8-1:0]   commit_strb_o,
  output logic                      commit_in_range_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(STRB_W);

  wr_state_t                state_q, state_d;
  logic                     pend_q, pend_d;
  logic [IDX_W-1:0]         wrIdx_q, wrIdx_d;
  logic [DATA_WIDTH-1:0]    wrData_q, wrData_d;
  logic [STRB_W-1:0]        wrStrb_q, wrStrb_d;
  logic [1:0]               bresp_q, bresp_d;
  logic                     awHeld, wHeld, awHs, wHs, inRange;
  logic [OFFS_W-1:0]        unusedOffset;

  assign unusedOffset = awaddr_i[OFFS_W-1:0];

  // pend_q marks "both halves held": the commit happens on the next edge
  assign awHeld    = (state_q == HAVE_AW) || pend_q;
  assign wHeld     = (state_q == HAVE_W) || pend_q;
  assign bvalid_o  = (state_q == RESP);
  assign awready_o = !rst_i && !awHeld && !bvalid_o;
  assign wready_o  = !rst_i && !wHeld && !bvalid_o;
  assign awHs      = awvalid_i && awready_o;
  assign wHs       = wvalid_i && wready_o;
  assign inRange   = (32'(wrIdx_q) < NUM_REGS);

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    wrIdx_d  = wrIdx_q;
    wrData_d = wrData_q;
    wrStrb_d = wrStrb_q;
    bresp_d  = bresp_q;
    if (awHs) wrIdx_d = awaddr_i[ADDRESS_WIDTH-1:OFFS_W];
    if (wHs) begin
      wrData_d = wdata_i;
      wrStrb_d = wstrb_i;
    end
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = RESP;
          bresp_d = inRange ? RESP_OKAY : RESP_SLVERR;
        end else if (awHs && wHs) begin
          pend_d = 1'b1;
        end else if (awHs) begin
          state_d = HAVE_AW;
        end else if (wHs) begin
          state_d = HAVE_W;
        end
      end
      HAVE_AW: if (wHs) begin
        state_d = IDLE;
        pend_d  = 1'b1;
      end
      HAVE_W: if (awHs) begin
        state_d = IDLE;
        pend_d  = 1'b1;
      end
      RESP:    if (bready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      wrIdx_q  <= '0;
      wrData_q <= '0;
      wrStrb_q <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      wrIdx_q  <= wrIdx_d;
      wrData_q <= wrData_d;
      wrStrb_q <= wrStrb_d;
      bresp_q  <= bresp_d;
    end
  end

  assign bresp_o           = bresp_q;
  assign commit_o          = pend_q;
  assign commit_idx_o      = wrIdx_q;
  assign commit_data_o     = wrData_q;
  assign commit_strb_o     = wrStrb_q;
  assign commit_in_range_o = inRange;

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite subordinate exposing NUM_REGS read/write registers plus per-register write pulses.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int NUM_REGS      = 8
) (
  input  logic                            axi_aclk_in,
  input  logic                            axi_areset_in,
  input  logic [ADDRESS_WIDTH-1:0]        axi_awaddr_in,
  input  logic [2:0]                      axi_awprot_in,
  input  logic                            axi_awvalid_in,
  output logic                            axi_awready_out,
  input  logic [DATA_WIDTH-1:0]           axi_wdata_in,
  input  logic [DATA_WIDTH/8-1:0]         axi_wstrb_in,
  input  logic                            axi_wvalid_in,
  output logic                            axi_wready_out,
  output logic [1:0]                      axi_bresp_out,
  output logic                            axi_bvalid_out,
  input  logic                            axi_bready_in,
  input  logic [ADDRESS_WIDTH-1:0]        axi_araddr_in,
  input  logic [2:0]                      axi_arprot_in,
  input  logic                            axi_arvalid_in,
  output logic                            axi_arready_out,
  output logic [DATA_WIDTH-1:0]           axi_rdata_out,
  output logic [1:0]                      axi_rresp_out,
  output logic                            axi_rvalid_out,
  input  logic                            axi_rready_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0]  regs_out,
  output logic [NUM_REGS-1:0]             reg_write_pulse_out
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(STRB_W);
  localparam int IDX_W  = ADDRESS_WIDTH - OFFS_W;

  logic                   commit, commitInRange;
  logic [IDX_W-1:0]       commitIdx;
  logic [DATA_WIDTH-1:0]  commitData;
  logic [STRB_W-1:0]      commitStrb;

  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]    pulse_q;
  logic                   rvalid_q;
  logic [DATA_WIDTH-1:0]  rdata_q, rdSel;
  logic [1:0]             rresp_q;
  logic [IDX_W-1:0]       arIdx;
  logic                   arInRange, arHs;
  logic                   unusedBits;

  assign unusedBits = ^{axi_awprot_in, axi_arprot_in, axi_araddr_in[OFFS_W-1:0]};

  axi_lite_write_ctrl #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .IDX_W        (IDX_W)
  ) u_write_ctrl (
    .clk_i            (axi_aclk_in),
    .rst_i            (axi_areset_in),
    .awaddr_i         (axi_awaddr_in),
    .awvalid_i        (axi_awvalid_in),
    .awready_o        (axi_awready_out),
    .wdata_i          (axi_wdata_in),
    .wstrb_i          (axi_wstrb_in),
    .wvalid_i         (axi_wvalid_in),
    .wready_o         (axi_wready_out),
    .bresp_o          (axi_bresp_out),
    .bvalid_o         (axi_bvalid_out),
    .bready_i         (axi_bready_in),
    .commit_o         (commit),
    .commit_idx_o     (commitIdx),
    .commit_data_o    (commitData),
    .commit_strb_o    (commitStrb),
    .commit_in_range_o(commitInRange)
  );

  always_ff @(posedge axi_aclk_in) begin
    if (axi_areset_in) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && commitInRange && (commitIdx == IDX_W'(i))) begin
          pulse_q[i] <= 1'b1;
          for (int j = 0; j < STRB_W; j++)
            if (commitStrb[j]) regs_q[i][j*8 +: 8] <= commitData[j*8 +: 8];
        end
      end
    end
  end

  // Read samples pre-commit contents, so a same-edge write is not visible yet
  assign arIdx     = axi_araddr_in[ADDRESS_WIDTH-1:OFFS_W];
  assign arInRange = (32'(arIdx) < NUM_REGS);
  assign axi_arready_out = !axi_areset_in && !rvalid_q;
  assign arHs      = axi_arvalid_in && axi_arready_out;

  always_comb begin
    rdSel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (arIdx == IDX_W'(i)) rdSel = regs_q[i];
  end

  always_ff @(posedge axi_aclk_in) begin
    if (axi_areset_in) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (arHs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= arInRange ? rdSel : '0;
      rresp_q  <= arInRange ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && axi_rready_in) begin
      rvalid_q <= 1'b0;
    end
  end

  assign axi_rvalid_out      = rvalid_q;
  assign axi_rdata_out       = rdata_q;
  assign axi_rresp_out       = rresp_q;
  assign reg_write_pulse_out = pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed test of axi_lite_regfile; B and R responses are checked by a scoreboard monitor.
module tb_axi_lite_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [255:0] regsOut;
  logic [7:0]  pulse;

  logic [1:0]  bExp[$];
  logic [33:0] rExp[$];
  logic [1:0]  bHead;
  logic [33:0] rHead;
  logic [31:0] model[8];
  int          assertCount = 0;
  int          failCount = 0;

  always #5 clk = ~clk;

  axi_lite_regfile #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(6), .NUM_REGS(8)
  ) dut (
    .axi_aclk_in        (clk),
    .axi_areset_in      (reset),
    .axi_awaddr_in      (awaddr),
    .axi_awprot_in      (awprot),
    .axi_awvalid_in     (awvalid),
    .axi_awready_out    (awready),
    .axi_wdata_in       (wdata),
    .axi_wstrb_in       (wstrb),
    .axi_wvalid_in      (wvalid),
    .axi_wready_out     (wready),
    .axi_bresp_out      (bresp),
    .axi_bvalid_out     (bvalid),
    .axi_bready_in      (bready),
    .axi_araddr_in      (araddr),
    .axi_arprot_in      (arprot),
    .axi_arvalid_in     (arvalid),
    .axi_arready_out    (arready),
    .axi_rdata_out      (rdata),
    .axi_rresp_out      (rresp),
    .axi_rvalid_out     (rvalid),
    .axi_rready_in      (rready),
    .regs_out           (regsOut),
    .reg_write_pulse_out(pulse)
  );

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] modelVec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  task automatic modelWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr >> 2);
    if (idx < 8)
      for (int j = 0; j < 4; j++)
        if (strb[j]) model[idx][j*8 +: 8] = data[j*8 +: 8];
  endtask

  // Returns one edge after the last AW/W handshake, i.e. just after the commit edge
  task automatic doWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [1:0] resp);
    logic awDone, wDone, awHs, wHs;
    bExp.push_back(resp);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    awDone = 1'b0; wDone = 1'b0;
    for (int n = 0; n < 20 && !(awDone && wDone); n++) begin
      awHs = awvalid && awready;
      wHs  = wvalid && wready;
      tick();
      if (awHs) begin awDone = 1'b1; awvalid = 1'b0; end
      if (wHs) begin wDone = 1'b1; wvalid = 1'b0; end
    end
    checkOutput("aw_w_handshake", {awDone, wDone}, 2'b11);
    tick();
    modelWrite(addr, data, strb);
  endtask

  task automatic doRead(input logic [5:0] addr, input logic [31:0] expData, input logic [1:0] expResp);
    logic done, hs;
    rExp.push_back({expResp, expData});
    araddr = addr; arvalid = 1'b1; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      hs = arvalid && arready;
      tick();
      if (hs) begin done = 1'b1; arvalid = 1'b0; end
    end
    checkOutput("ar_handshake", done, 1'b1);
    for (int n = 0; n < 20 && rvalid; n++) tick();
  endtask

  // Scoreboard monitor: pops an expectation whenever a B or R beat is accepted
  always @(negedge clk) begin
    if (!reset) begin
      if (bvalid && bready) begin
        if (bExp.size() == 0) checkOutput("b_unexpected", 1'b1, 1'b0);
        else begin
          bHead = bExp.pop_front();
          checkOutput("bresp", bresp, bHead);
        end
      end
      if (rvalid && rready) begin
        if (rExp.size() == 0) checkOutput("r_unexpected", 1'b1, 1'b0);
        else begin
          rHead = rExp.pop_front();
          checkOutput("rresp_rdata", {rresp, rdata}, rHead);
        end
      end
    end
  end

  task automatic checkAllZero(input string name);
    checkOutput({name, "_readys"}, {awready, wready, arready}, 3'b000);
    checkOutput({name, "_valids"}, {bvalid, rvalid}, 2'b00);
    checkOutput({name, "_resps"}, {bresp, rresp}, 4'b0000);
    checkOutput({name, "_rdata"}, rdata, 32'h0);
    checkOutput({name, "_regs"}, regsOut, 256'h0);
    checkOutput({name, "_pulse"}, pulse, 8'h00);
  endtask

  task automatic applyStimulus();
    // Reset state
    repeat (2) tick();
    checkAllZero("reset");
    reset = 1'b0;
    tick();
    checkOutput("post_reset_readys", {awready, wready, arready}, 3'b111);

    // AW and W together, full strobe
    doWrite(6'h04, 32'hDEADBEEF, 4'hF, 2'b00);
    checkOutput("w1_bvalid", bvalid, 1'b1);
    checkOutput("w1_reg1", regsOut[63:32], 32'hDEADBEEF);
    checkOutput("w1_pulse", pulse, 8'h02);
    tick();
    checkOutput("w1_pulse_end", pulse, 8'h00);
    checkOutput("w1_bvalid_end", bvalid, 1'b0);
    doRead(6'h04, 32'hDEADBEEF, 2'b00);

    // W two cycles ahead of AW
    bExp.push_back(2'b00);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checkOutput("w2_readys_after_w", {awready, wready}, 2'b10);
    tick();
    awaddr = 6'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checkOutput("w2_held_both", {awready, wready, bvalid}, 3'b000);
    tick();
    modelWrite(6'h08, 32'hCAFEF00D, 4'hF);
    checkOutput("w2_reg2", regsOut[95:64], 32'hCAFEF00D);
    checkOutput("w2_pulse", pulse, 8'h04);
    tick();

    // Partial strobe
    doWrite(6'h00, 32'h11223344, 4'hF, 2'b00);
    tick();
    doWrite(6'h00, 32'hAABBCCDD, 4'b0101, 2'b00);
    checkOutput("w3_reg0", regsOut[31:0], 32'h11BB33DD);
    checkOutput("w3_pulse", pulse, 8'h01);
    tick();

    // Out-of-range write and read
    doWrite(6'h20, 32'h12345678, 4'hF, 2'b10);
    checkOutput("oor_bvalid", bvalid, 1'b1);
    checkOutput("oor_pulse", pulse, 8'h00);
    checkOutput("oor_regs", regsOut, modelVec());
    tick();
    doRead(6'h3C, 32'h0, 2'b10);

    // Backpressure on B and R plus same-edge commit/read of reg3
    doWrite(6'h0C, 32'h5, 4'hF, 2'b00);
    tick();
    bready = 1'b0; rready = 1'b0;
    bExp.push_back(2'b00);
    rExp.push_back({2'b00, 32'h5});
    awaddr = 6'h0C; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h0C; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    modelWrite(6'h0C, 32'h9, 4'hF);
    checkOutput("col_reg3", regsOut[127:96], 32'h9);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_b_hold", {bvalid, bresp, awready, wready}, 5'b1_00_00);
      checkOutput("bp_r_hold", {rvalid, arready, rdata}, {2'b10, 32'h5});
      tick();
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    checkOutput("bp_released", {bvalid, rvalid}, 2'b00);

    // Reset while HAVE_AW drops the write
    awaddr = 6'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checkOutput("rst_have_aw", {awready, wready}, 2'b01);
    reset = 1'b1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    checkAllZero("mid_reset");
    reset = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    tick();
    checkOutput("rst_no_commit", {bvalid, pulse}, 9'h0);
    checkOutput("rst_regs", regsOut, modelVec());
    doWrite(6'h14, 32'h0BADF00D, 4'hF, 2'b00);
    checkOutput("rst_new_write", regsOut, modelVec());
    checkOutput("rst_new_pulse", pulse, 8'h20);
    tick();
    doRead(6'h14, 32'h0BADF00D, 2'b00);
    doRead(6'h10, 32'h0, 2'b00);
    repeat (3) tick();
    checkOutput("scoreboard_drained", 32'(bExp.size() + rExp.size()), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
